// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/MEM request ports, the arbiter and the shared memory.
// slave is the arbiter's view; master is the pipeline/memory side's view.
interface mem_port_arbiter_if #(
  parameter int unsigned AddrW = 32,
  parameter int unsigned DataW = 32
);
  logic             if_req;
  logic [AddrW-1:0] if_addr;
  logic [DataW-1:0] if_rdata;
  logic             if_ack;
  logic             if_stall;

  logic             d_req;
  logic             d_we;
  logic [AddrW-1:0] d_addr;
  logic [DataW-1:0] d_wdata;
  logic [DataW-1:0] d_rdata;
  logic             d_ack;
  logic             d_stall;

  logic             m_req;
  logic             m_we;
  logic [AddrW-1:0] m_addr;
  logic [DataW-1:0] m_wdata;
  logic [DataW-1:0] m_rdata;
  logic             m_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    output if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall, m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    input  if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall, m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the data port, one transaction
// at a time, with a watchdog that forces completion when the memory never answers.
module mem_port_arbiter #(
  parameter int unsigned AddrW   = 32,
  parameter int unsigned DataW   = 32,
  parameter int unsigned Timeout = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_port_arbiter_if.slave bus_io,
  output logic              bus_err_o
);

  localparam int unsigned    CntW    = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e           state_q, state_d;
  logic             last_d_q, last_d_d;  // data port won the most recent grant
  logic [CntW-1:0]  wait_cnt_q, wait_cnt_d;
  logic             m_req_q, m_req_d;
  logic             m_we_q, m_we_d;
  logic [AddrW-1:0] m_addr_q, m_addr_d;
  logic [DataW-1:0] m_wdata_q, m_wdata_d;
  logic [DataW-1:0] if_rdata_q, if_rdata_d;
  logic [DataW-1:0] d_rdata_q, d_rdata_d;
  logic             if_ack_q, if_ack_d;
  logic             d_ack_q, d_ack_d;
  logic             bus_err_q, bus_err_d;
  logic             i_pend, d_pend;

  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    wait_cnt_d = wait_cnt_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    bus_err_d  = bus_err_q;
    // A request seen in its own ack cycle is the one just served, not a new one.
    i_pend     = bus_io.if_req & ~if_ack_q;
    d_pend     = bus_io.d_req & ~d_ack_q;

    unique case (state_q)
      StIdle: begin
        if (d_pend && (!i_pend || !last_d_q)) begin
          state_d    = StBusyD;
          last_d_d   = 1'b1;
          wait_cnt_d = '0;
          m_req_d    = 1'b1;
          m_we_d     = bus_io.d_we;
          m_addr_d   = bus_io.d_addr;
          m_wdata_d  = bus_io.d_wdata;
        end else if (i_pend) begin
          state_d    = StBusyI;
          last_d_d   = 1'b0;
          wait_cnt_d = '0;
          m_req_d    = 1'b1;
          m_we_d     = 1'b0;
          m_addr_d   = bus_io.if_addr;
          m_wdata_d  = '0;
        end
      end
      StBusyI, StBusyD: begin
        if (bus_io.m_ready || (wait_cnt_q == CntLast)) begin
          state_d = StIdle;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          if (!bus_io.m_ready) begin
            bus_err_d = 1'b1;
          end
          if (state_q == StBusyI) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus_io.m_ready ? bus_io.m_rdata : '0;
          end else begin
            d_ack_d = 1'b1;
            if (!m_we_q) begin
              d_rdata_d = bus_io.m_ready ? bus_io.m_rdata : '0;
            end
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      last_d_q   <= 1'b0;
      wait_cnt_q <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      wait_cnt_q <= wait_cnt_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign bus_io.m_req    = m_req_q;
  assign bus_io.m_we     = m_we_q;
  assign bus_io.m_addr   = m_addr_q;
  assign bus_io.m_wdata  = m_wdata_q;
  assign bus_io.if_rdata = if_rdata_q;
  assign bus_io.d_rdata  = d_rdata_q;
  assign bus_io.if_ack   = if_ack_q;
  assign bus_io.d_ack    = d_ack_q;
  assign bus_io.if_stall = bus_io.if_req & ~if_ack_q;
  assign bus_io.d_stall  = bus_io.d_req & ~d_ack_q;
  assign bus_err_o       = bus_err_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-ported unified memory between the pipeline's instruction-fetch port (read-only) and its MEM-stage data port (load/store). Sits between the IF/MEM stages and the shared memory. Issues one transaction at a time and returns a one-cycle acknowledge to the granted requester. Drives per-port stall signals so the hazard logic can freeze the PC, IF/ID and EX/MEM while a port waits. A timeout watchdog guarantees the pipeline never hangs on a silent memory.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- TIMEOUT, 15, maximum cycles a transaction may wait for m_ready (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; level, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word; valid in the if_ack cycle, then held
- if_ack  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  if_req && !if_ack
- d_req  in  1  data request; level, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid in the d_ack cycle, then held
- d_ack  out  1  one-cycle completion pulse for data
- d_stall  out  1  d_req && !d_ack
- m_req  out  1  memory transaction active
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid when m_ready
- m_ready  in  1  memory completes the current transaction this cycle
- bus_err  out  1  sticky timeout flag

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - d_req only → BUSY_D.
  - if_req only → BUSY_I.
  - Both → BUSY_D, unless last_grant==D, then BUSY_I.
  - Neither → stay in IDLE.
  - On every grant, register m_req=1, m_we (d_we for D, 0 for I), m_addr and m_wdata from the granted port, and record last_grant.
- BUSY_x:
  - m_req/m_we/m_addr/m_wdata are held stable. Input changes are ignored until completion.
  - m_ready=1 → capture m_rdata into x_rdata (reads only; stores leave d_rdata unchanged). Pulse x_ack next cycle, drop m_req, go to IDLE.
- Watchdog:
  - wait_cnt clears on grant and increments each BUSY cycle without m_ready.
  - When wait_cnt==TIMEOUT-1 and m_ready=0: drop m_req, set bus_err, pulse x_ack with x_rdata=0 (loads and fetches), go to IDLE.
  - bus_err clears only on reset.
- Requester rule: after x_ack, the requester deasserts x_req or presents a new request. A request still asserted in the cycle after ack is treated as new.
- No write forwarding or buffering: the arbiter never reorders or merges transactions.

## Timing
- Reset (reset=0, asynchronous): state=IDLE; last_grant=I; wait_cnt=0; m_req=m_we=0; m_addr=m_wdata=0; if_rdata=d_rdata=0; if_ack=d_ack=0; bus_err=0. if_stall/d_stall follow their request inputs.
- Reset asserted mid-transaction: m_req drops immediately and no ack is issued. Requesters re-request after reset.
- Latency with an idle arbiter and zero-wait memory:
  - Request sampled in cycle 0.
  - m_req high in cycle 1; m_ready in cycle 1.
  - x_ack and x_rdata in cycle 2.
  - Next grant no earlier than cycle 3 (one IDLE bubble per transaction).
- Each memory wait state adds one cycle.
- Timeout ack arrives in cycle TIMEOUT+1 after the grant cycle.
- m_ready sampled while m_req=0 is ignored.
- The if_ack and d_ack pulses are never high in the same cycle.
- Stall outputs are combinational from x_req and registered x_ack only; there are no other combinational input-to-output paths.

## Test plan
- Single load: d_req=1, d_we=0, d_addr=0x40, memory returns 0xDEADBEEF with zero wait → m_req in cycle 1 with m_addr=0x40, d_ack and d_rdata=0xDEADBEEF in cycle 2; d_stall high in cycles 0–1.
- Contention from reset: if_req and d_req raised together and kept asserted → grant order D, I, D, I. After the D ack, if_stall stays high until the I ack. last_grant alternates.
- Store with waits: d_we=1, d_addr=0x10, d_wdata=0x12345678, m_ready after 3 wait cycles → m_we=1 and m_wdata stable for 4 cycles, d_ack in cycle 5, d_rdata unchanged.
- Timeout (TIMEOUT=15): fetch granted, m_ready held 0 → m_req drops after 15 busy cycles, if_ack with if_rdata=0, bus_err=1 and stays 1 across later successful transactions.
- Reset mid-operation: assert reset in cycle 2 of a 5-wait-state load → all outputs return to reset values asynchronously, no d_ack. After release with d_req still high, a fresh grant occurs.
- Stability: change d_addr from 0x40 to 0x80 while in BUSY_D → m_addr stays 0x40 until completion.
